// File: rtl/rv32v_types_pkg.sv
// Shared types for the RV32V reorder buffer: per-entry record and default sizing.
package rv32v_types_pkg;

   localparam int ROB_DEPTH  = 16;
   localparam int ROB_DATA_W = 64;

   typedef struct packed {
      logic                  valid;
      logic                  ready;
      logic                  exc;
      logic [4:0]            vd;
      logic                  last;
      logic [ROB_DATA_W-1:0] wdata;
      logic [1:0]            wen;
      logic [4:0]            woffset;
   } rob_entry_t;

endpackage

// File: rtl/rv32v_rob_ptr.sv
// Wrap-bit ROB pointer with full/empty comparison against its peer pointer.
module rv32v_rob_ptr #(
   parameter int IDX_W = 4
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [IDX_W:0]   i_loadVal,
   input  logic             i_inc,
   input  logic [IDX_W:0]   i_peer,
   output logic [IDX_W:0]   o_ptr,
   output logic             o_full,
   output logic             o_empty
);

   logic [IDX_W:0] r_ptr;

   // Clear beats load beats increment, so a squash or flush always wins over a same-cycle advance.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_ptr <= '0;
      end else if (i_clear) begin
         r_ptr <= '0;
      end else if (i_load) begin
         r_ptr <= i_loadVal;
      end else if (i_inc) begin
         r_ptr <= r_ptr + 1'b1;
      end
   end

   assign o_ptr   = r_ptr;
   assign o_full  = (r_ptr[IDX_W] != i_peer[IDX_W]) && (r_ptr[IDX_W-1:0] == i_peer[IDX_W-1:0]);
   assign o_empty = (r_ptr == i_peer);

endmodule

// File: rtl/rv32v_reorder_buffer.sv
// In-order retirement buffer between rv32v_memory_stage and the vector register file writeback.
// Define RV32V_ROB_BYPASS_EN to let a clean result for the head entry commit in the same cycle.
module rv32v_reorder_buffer
   import rv32v_types_pkg::*;
#(
   parameter int DEPTH  = ROB_DEPTH,
   parameter int IDX_W  = $clog2(DEPTH),
   parameter int DATA_W = ROB_DATA_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              alloc_req,
   input  logic [4:0]        alloc_vd,
   input  logic              alloc_last,
   output logic              alloc_ack,
   output logic [IDX_W-1:0]  alloc_index,
   output logic              full,
   output logic              empty,
   input  logic              result_valid,
   input  logic [IDX_W-1:0]  result_index,
   input  logic [DATA_W-1:0] result_wdata,
   input  logic [1:0]        result_wen,
   input  logic [4:0]        result_woffset,
   input  logic              result_exception,
   output logic              commit_valid,
   input  logic              commit_ready,
   output logic [4:0]        commit_vd,
   output logic [DATA_W-1:0] commit_wdata,
   output logic [1:0]        commit_wen,
   output logic [4:0]        commit_woffset,
   output logic              commit_last,
   output logic              exception_valid,
   output logic [IDX_W-1:0]  exception_index
);

   rob_entry_t       r_entries [DEPTH];
   logic             r_excValid;
   logic [IDX_W-1:0] r_excIndex;

   logic [IDX_W:0]   w_headPtr;
   logic [IDX_W:0]   w_tailPtr;
   logic [IDX_W-1:0] w_headIdx;
   logic [IDX_W-1:0] w_tailIdx;
   logic             w_headFull;
   logic             w_headEmpty;
   logic             w_tailFull;
   logic             w_tailEmpty;
   rob_entry_t       w_head;
   logic             w_headFault;
   logic             w_allocAck;
   logic             w_resultHit;
   logic             w_bypass;
   logic             w_commitValid;
   logic             w_commitFire;
   logic             w_squash;

   assign w_headIdx   = w_headPtr[IDX_W-1:0];
   assign w_tailIdx   = w_tailPtr[IDX_W-1:0];
   assign w_head      = r_entries[w_headIdx];
   assign w_headFault = w_head.valid && w_head.ready && w_head.exc;
   assign w_squash    = w_headFault && !flush;

   assign w_allocAck  = alloc_req && !w_tailFull && !flush && !w_headFault;
   assign w_resultHit = result_valid && r_entries[result_index].valid
                        && !r_entries[result_index].ready;

`ifdef RV32V_ROB_BYPASS_EN
   assign w_bypass = result_valid && (result_index == w_headIdx) && w_head.valid
                     && !w_head.ready && !result_exception;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_commitValid = (w_head.valid && w_head.ready && !w_head.exc) || w_bypass;
   assign w_commitFire  = w_commitValid && commit_ready && !flush;

   rv32v_rob_ptr #(.IDX_W(IDX_W)) u_headPtr (
      .CLK       (CLK),
      .nRST      (nRST),
      .i_clear   (flush),
      .i_load    (1'b0),
      .i_loadVal ('0),
      .i_inc     (w_commitFire),
      .i_peer    (w_tailPtr),
      .o_ptr     (w_headPtr),
      .o_full    (w_headFull),
      .o_empty   (w_headEmpty)
   );

   // A squash rewinds the tail onto the faulting head so nothing younger survives.
   rv32v_rob_ptr #(.IDX_W(IDX_W)) u_tailPtr (
      .CLK       (CLK),
      .nRST      (nRST),
      .i_clear   (flush),
      .i_load    (w_squash),
      .i_loadVal (w_headPtr),
      .i_inc     (w_allocAck),
      .i_peer    (w_headPtr),
      .o_ptr     (w_tailPtr),
      .o_full    (w_tailFull),
      .o_empty   (w_tailEmpty)
   );

   // Both pointer instances compare the same pair, so their flags always agree.
   assign full  = w_tailFull  | w_headFull;
   assign empty = w_tailEmpty & w_headEmpty;

   // Later assignments override earlier ones: commit frees the head, squash and flush clear everything.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entries[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entries[i].valid <= 1'b0;
            r_entries[i].ready <= 1'b0;
            r_entries[i].exc   <= 1'b0;
         end
      end else begin
         if (w_resultHit) begin
            r_entries[result_index].wdata   <= result_wdata;
            r_entries[result_index].wen     <= result_wen;
            r_entries[result_index].woffset <= result_woffset;
            r_entries[result_index].ready   <= 1'b1;
            r_entries[result_index].exc     <= result_exception;
         end
         if (w_allocAck) begin
            r_entries[w_tailIdx].valid <= 1'b1;
            r_entries[w_tailIdx].ready <= 1'b0;
            r_entries[w_tailIdx].exc   <= 1'b0;
            r_entries[w_tailIdx].vd    <= alloc_vd;
            r_entries[w_tailIdx].last  <= alloc_last;
         end
         if (w_commitFire) begin
            r_entries[w_headIdx].valid <= 1'b0;
         end
         if (w_headFault) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_entries[i].valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_excValid <= 1'b0;
         r_excIndex <= '0;
      end else begin
         r_excValid <= w_squash;
         if (w_squash) begin
            r_excIndex <= w_headIdx;
         end
      end
   end

   // Commit payload is zero whenever the head slot is empty.
   always_comb begin
      commit_vd      = '0;
      commit_last    = 1'b0;
      commit_wdata   = '0;
      commit_wen     = '0;
      commit_woffset = '0;
      if (w_head.valid) begin
         commit_vd   = w_head.vd;
         commit_last = w_head.last;
         if (w_bypass) begin
            commit_wdata   = result_wdata;
            commit_wen     = result_wen;
            commit_woffset = result_woffset;
         end else begin
            commit_wdata   = w_head.wdata;
            commit_wen     = w_head.wen;
            commit_woffset = w_head.woffset;
         end
      end
   end

   assign alloc_ack       = w_allocAck;
   assign alloc_index     = w_tailIdx;
   assign commit_valid    = w_commitValid;
   assign exception_valid = r_excValid;
   assign exception_index = r_excIndex;

endmodule
